irq_capture_encoder: RTL and testbench

//  Front-end for the 8-line priority encoder path. Synchronises N asynchronous request lines,

---
 rtl/irq_pkg.sv | 11 +
 rtl/irq_pri_sel.sv | 24 ++
 rtl/irq_capture_encoder.sv | 96 +++++++++
 tb/tb_irq_capture_encoder.sv | 190 +++++++++++++++++++
 4 files changed

// File: rtl/irq_pkg.sv
// Shared sizing and types for the interrupt request capture / priority-encode path.
package irq_pkg;

  localparam int N               = 8;
  localparam int W               = 3;
  localparam int SYNC_STAGES_DEF = 2;

  typedef logic [W-1:0] irq_id_t;
  typedef logic [N-1:0] irq_vec_t;

endpackage

// File: rtl/irq_pri_sel.sv
// Combinational highest-index-wins selector: reports whether any bit is set and its index.
module irq_pri_sel #(
  parameter int N = irq_pkg::N,
  parameter int W = irq_pkg::W
) (
  input  logic [N-1:0] vec,
  output logic         any,
  output logic [W-1:0] id
);
  import irq_pkg::*;

  // Ascending scan: the last set bit seen is the highest index, so it wins.
  always_comb begin
    any = 1'b0;
    id  = '0;
    for (int i = 0; i < N; i++) begin
      if (vec[i]) begin
        any = 1'b1;
        id  = W'(i);
      end
    end
  end

endmodule

// File: rtl/irq_capture_encoder.sv
// Synchronises request lines, latches rising edges as sticky pending bits and presents the
// highest-priority unmasked pending request as a registered id on a valid/ready handshake.
module irq_capture_encoder #(
  parameter int N           = irq_pkg::N,
  parameter int W           = irq_pkg::W,
  parameter int SYNC_STAGES = irq_pkg::SYNC_STAGES_DEF
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [N-1:0] req_in,
  input  logic [N-1:0] mask,
  input  logic         irq_ready,
  output logic         irq_valid,
  output logic [W-1:0] irq_id,
  output logic [N-1:0] pending,
  output logic [N-1:0] overrun
);
  import irq_pkg::*;

  logic [N-1:0] sync_q [SYNC_STAGES];
  logic [N-1:0] hist_q;
  logic [N-1:0] pend_q;
  logic [N-1:0] ovr_q;
  logic         vld_q;
  logic [W-1:0] id_q;

  logic [N-1:0] sync_out;
  logic [N-1:0] rise;
  logic [N-1:0] accept;
  logic [N-1:0] cand;
  logic [N-1:0] pend_d;
  logic [N-1:0] ovr_d;
  logic         fire;
  logic         sel_any;
  logic [W-1:0] sel_id;

  // Synchroniser chain and edge history
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int k = 0; k < SYNC_STAGES; k++) sync_q[k] <= '0;
      hist_q <= '0;
    end else begin
      sync_q[0] <= req_in;
      for (int k = 1; k < SYNC_STAGES; k++) sync_q[k] <= sync_q[k-1];
      hist_q <= sync_out;
    end
  end

  assign sync_out = sync_q[SYNC_STAGES-1];
  assign rise     = sync_out & ~hist_q;
  assign fire     = vld_q & irq_ready;

  always_comb begin
    accept = '0;
    if (fire) accept[id_q] = 1'b1;
  end

  // A same-edge rise beats the accept clear; an overrun only counts when the bit survives.
  assign pend_d = rise | (pend_q & ~accept);
  assign ovr_d  = rise & pend_q & ~accept;

  // Candidates use the registered pending so same-edge rises wait one cycle to be presented.
  assign cand = pend_q & mask & ~accept;

  irq_pri_sel #(
    .N (N),
    .W (W)
  ) u_pri_sel (
    .vec (cand),
    .any (sel_any),
    .id  (sel_id)
  );

  // Pending / overrun state and the presented-id register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pend_q <= '0;
      ovr_q  <= '0;
      vld_q  <= 1'b0;
      id_q   <= '0;
    end else begin
      pend_q <= pend_d;
      ovr_q  <= ovr_d;
      if (!vld_q || fire) begin
        vld_q <= sel_any;
        if (sel_any) id_q <= sel_id;
      end
    end
  end

  assign irq_valid = vld_q;
  assign irq_id    = id_q;
  assign pending   = pend_q;
  assign overrun   = ovr_q;

endmodule

// File: tb/tb_irq_capture_encoder.sv
// Directed bench for irq_capture_encoder: a vector table plus hand-written multi-cycle sequences.
module tb_irq_capture_encoder;

  logic       clk;
  logic       rst;
  logic [7:0] req_in;
  logic [7:0] mask;
  logic       irq_ready;
  logic       irq_valid;
  logic [2:0] irq_id;
  logic [7:0] pending;
  logic [7:0] overrun;

  int n_cmp;
  int n_err;

  typedef struct {
    logic [7:0] req;
    logic [7:0] msk;
    logic       rdy;
    int         ncyc;
    logic       vld;
    logic [2:0] id;
    logic [7:0] pend;
    logic [7:0] ovr;
  } vec_t;

  vec_t tbl [17];

  irq_capture_encoder #(
    .N           (8),
    .W           (3),
    .SYNC_STAGES (2)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .req_in    (req_in),
    .mask      (mask),
    .irq_ready (irq_ready),
    .irq_valid (irq_valid),
    .irq_id    (irq_id),
    .pending   (pending),
    .overrun   (overrun)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // irq_id is only meaningful while irq_valid is high
  task automatic chk_all(input string nm, input logic vld, input logic [2:0] id,
                         input logic [7:0] pend, input logic [7:0] ovr);
    chk({nm, ".valid"}, 32'(irq_valid), 32'(vld));
    if (vld) chk({nm, ".id"}, 32'(irq_id), 32'(id));
    chk({nm, ".pending"}, 32'(pending), 32'(pend));
    chk({nm, ".overrun"}, 32'(overrun), 32'(ovr));
  endtask

  initial begin
    n_cmp     = 0;
    n_err     = 0;
    rst       = 1'b1;
    req_in    = 8'h00;
    mask      = 8'hFF;
    irq_ready = 1'b0;

    //           req    mask   rdy  n   vld   id    pend   ovr
    tbl[0]  = '{8'h00, 8'hFF, 1'b0, 10, 1'b0, 3'd0, 8'h00, 8'h00};
    tbl[1]  = '{8'h24, 8'hFF, 1'b0, 1,  1'b0, 3'd0, 8'h00, 8'h00};
    tbl[2]  = '{8'h24, 8'hFF, 1'b0, 1,  1'b0, 3'd0, 8'h00, 8'h00};
    tbl[3]  = '{8'h24, 8'hFF, 1'b0, 1,  1'b0, 3'd0, 8'h24, 8'h00};
    tbl[4]  = '{8'h24, 8'hFF, 1'b0, 1,  1'b1, 3'd5, 8'h24, 8'h00};
    tbl[5]  = '{8'h24, 8'hFF, 1'b0, 3,  1'b1, 3'd5, 8'h24, 8'h00};
    tbl[6]  = '{8'h24, 8'hFF, 1'b1, 1,  1'b1, 3'd2, 8'h04, 8'h00};
    tbl[7]  = '{8'h24, 8'hFF, 1'b1, 1,  1'b0, 3'd0, 8'h00, 8'h00};
    tbl[8]  = '{8'h00, 8'hFF, 1'b0, 4,  1'b0, 3'd0, 8'h00, 8'h00};
    tbl[9]  = '{8'hF0, 8'h0F, 1'b0, 3,  1'b0, 3'd0, 8'hF0, 8'h00};
    tbl[10] = '{8'hF0, 8'h0F, 1'b0, 3,  1'b0, 3'd0, 8'hF0, 8'h00};
    tbl[11] = '{8'hF0, 8'hFF, 1'b0, 1,  1'b1, 3'd7, 8'hF0, 8'h00};
    tbl[12] = '{8'hF0, 8'hFF, 1'b1, 1,  1'b1, 3'd6, 8'h70, 8'h00};
    tbl[13] = '{8'hF0, 8'hFF, 1'b1, 1,  1'b1, 3'd5, 8'h30, 8'h00};
    tbl[14] = '{8'hF0, 8'hFF, 1'b1, 1,  1'b1, 3'd4, 8'h10, 8'h00};
    tbl[15] = '{8'hF0, 8'hFF, 1'b1, 1,  1'b0, 3'd0, 8'h00, 8'h00};
    tbl[16] = '{8'h00, 8'hFF, 1'b0, 4,  1'b0, 3'd0, 8'h00, 8'h00};

    tick(2);
    chk_all("reset", 1'b0, 3'd0, 8'h00, 8'h00);
    rst = 1'b0;

    for (int i = 0; i < 17; i++) begin
      req_in    = tbl[i].req;
      mask      = tbl[i].msk;
      irq_ready = tbl[i].rdy;
      tick(tbl[i].ncyc);
      chk_all($sformatf("v%0d", i), tbl[i].vld, tbl[i].id, tbl[i].pend, tbl[i].ovr);
    end

    // Presented id holds while a higher-priority line arrives
    req_in = 8'h08;
    tick(4);
    chk_all("hold.pres3", 1'b1, 3'd3, 8'h08, 8'h00);
    req_in = 8'h88;
    tick(5);
    chk_all("hold.still3", 1'b1, 3'd3, 8'h88, 8'h00);
    irq_ready = 1'b1;
    tick(1);
    chk_all("hold.next7", 1'b1, 3'd7, 8'h80, 8'h00);
    tick(1);
    chk_all("hold.drain", 1'b0, 3'd0, 8'h00, 8'h00);
    irq_ready = 1'b0;
    req_in    = 8'h00;
    tick(4);

    // Overrun on a bit already pending but not presented
    req_in = 8'h82;
    tick(4);
    chk_all("ovr.setup", 1'b1, 3'd7, 8'h82, 8'h00);
    req_in = 8'h80;
    tick(1);
    req_in = 8'h82;
    tick(1);
    tick(1);
    chk_all("ovr.before", 1'b1, 3'd7, 8'h82, 8'h00);
    tick(1);
    chk_all("ovr.pulse", 1'b1, 3'd7, 8'h82, 8'h02);
    tick(1);
    chk_all("ovr.after", 1'b1, 3'd7, 8'h82, 8'h00);
    irq_ready = 1'b1;
    tick(2);
    chk_all("ovr.drain", 1'b0, 3'd0, 8'h00, 8'h00);
    irq_ready = 1'b0;
    req_in    = 8'h00;
    tick(4);

    // Rise on bit 4 at the same edge it is accepted
    req_in = 8'h10;
    tick(4);
    chk_all("same.pres4", 1'b1, 3'd4, 8'h10, 8'h00);
    req_in = 8'h00;
    tick(1);
    req_in = 8'h10;
    tick(2);
    irq_ready = 1'b1;
    tick(1);
    chk_all("same.edge", 1'b0, 3'd0, 8'h10, 8'h00);
    tick(1);
    chk_all("same.repres", 1'b1, 3'd4, 8'h10, 8'h00);
    tick(1);
    chk_all("same.drain", 1'b0, 3'd0, 8'h00, 8'h00);
    irq_ready = 1'b0;
    req_in    = 8'h00;
    tick(4);

    // Asynchronous reset mid-operation, with line 0 held high through it
    req_in = 8'h81;
    tick(4);
    chk_all("rst.setup", 1'b1, 3'd7, 8'h81, 8'h00);
    req_in = 8'h01;
    #2 rst = 1'b1;
    #1;
    chk_all("rst.async", 1'b0, 3'd0, 8'h00, 8'h00);
    chk("rst.id", 32'(irq_id), 32'h0);
    tick(2);
    rst = 1'b0;
    tick(3);
    chk_all("rst.pend0", 1'b0, 3'd0, 8'h01, 8'h00);
    tick(1);
    chk_all("rst.pres0", 1'b1, 3'd0, 8'h01, 8'h00);
    irq_ready = 1'b1;
    tick(1);
    chk_all("rst.acc0", 1'b0, 3'd0, 8'h00, 8'h00);
    tick(4);
    chk_all("rst.once", 1'b0, 3'd0, 8'h00, 8'h00);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
